step_debouncer: RTL
===================

// Module: step_debouncer
// PURPOSE
//  Input-side conditioner for the board push-button/switch that single-steps the computer.
//  It synchronises and debounces the raw switch and presents a clean level.
//  It emits one-cycle step pulses on clk: one per press, plus optional auto-repeat while held.
//  It also keeps a wrapping count of issued steps for the display path.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable samples to accept a press/release (>=1)
//  REPEAT_DELAY     25000000 cycles held after first step before first auto-repeat step (>=1)
//  REPEAT_PERIOD    5000000 cycles between subsequent auto-repeat steps (>=1)
// PORTS
//  clk          in   1  system clock; single clock domain
//  rst          in   1  synchronous reset, active-high
//  sw_raw       in   1  raw, asynchronous, bouncing switch input
//  repeat_en    in   1  1 = auto-repeat steps while held; 0 = one step per press
//  sw_level     out  1  debounced switch level
//  step         out  1  one-cycle pulse per accepted step
//  step_count   out  8  number of step pulses issued, modulo 256
// BEHAVIOUR
//  Reset: rst sampled high at a clk edge clears all state.
//   - Synchroniser flops=0, state=RELEASED, all counters=0.
//   - sw_level=0, step=0, step_count=0 from the next cycle.
//   - rst wins over every other event.
//  Synchroniser: 2 flops; sw_sync = sw_raw delayed by 2 edges.
//  FSM, all outputs registered:
//   RELEASED: sw_sync=1 -> PRESS_WAIT, db_cnt=1.
//   PRESS_WAIT:
//     - sw_sync=0 -> RELEASED; no step is issued.
//     - Else, when db_cnt==DEBOUNCE_CYCLES -> PRESSED, step=1 for that cycle only, sw_level=1, rep_cnt=0.
//     - Otherwise db_cnt++.
//   PRESSED:
//     - sw_sync=0 -> RELEASE_WAIT, db_cnt=1.
//     - Else, if repeat_en=1: rep_cnt++.
//       - Step pulse when rep_cnt reaches REPEAT_DELAY (first repeat).
//       - Then every REPEAT_PERIOD cycles.
//     - If repeat_en=0: rep_cnt held at 0 and the repeat phase restarts.
//   RELEASE_WAIT:
//     - sw_sync=1 -> PRESSED, rep_cnt=0, no step.
//     - Else, when db_cnt==DEBOUNCE_CYCLES -> RELEASED, sw_level=0.
//     - Otherwise db_cnt++.
//  Latency:
//   - From the first clk edge at which sw_raw is stably 1, step is high in the cycle after edge DEBOUNCE_CYCLES+2.
//   - sw_level falls with the same latency after a stable release.
//  Pulse spacing: step is never high on two consecutive cycles; REPEAT_PERIOD=1 is clamped to 2.
//  Glitches: any bounce shorter than DEBOUNCE_CYCLES samples causes no step and no sw_level change.
//  step_count: increments by 1 in the same cycle step=1; wraps 255 -> 0.
//  Counter widths: sized by $clog2 of the largest parameter + 1; counters never overflow.
//  sw_raw held high through reset: after rst is released it is treated as a new press.
//   - Full debounce runs, then one step is issued.
//  Mid-operation reset: any pending debounce or repeat is abandoned; no step in or after the reset cycle until a new debounce completes.
//  repeat_en may change at any time:
//   - Rising while PRESSED starts the REPEAT_DELAY timing from that cycle.
//   - Falling stops further repeats immediately.
// TESTING  (bench overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1. rst=1 for 2 cycles, then sw_raw=0 -> sw_level=0, step=0, step_count=0 for 20 cycles.
//  2. sw_raw 0->1 held, repeat_en=0 -> exactly one step pulse 6 edges later.
//     - sw_level=1 and step_count=1 from then on; no further pulses over 50 cycles.
//  3. Press glitches high for 3 cycles, low for 2, repeated 5x, then low -> no step; sw_level stays 0.
//  4. Clean press, then release glitch of 3 cycles low -> sw_level stays 1, no extra step.
//     - A clean release then drops sw_level 6 edges after the last low edge begins.
//  5. repeat_en=1, press held 40 cycles -> steps at t, t+10, t+13, t+16, ... while held.
//     - No step after release; step_count matches the pulse count.
//  6. Assert rst mid-PRESS_WAIT and mid-repeat, with sw_raw held 1:
//     - Outputs go to 0 the cycle after rst.
//     - The next step comes 6 edges after rst deasserts.
//  7. Apply 258 presses -> step_count reads 2 (wrap).

Source files
------------

// File: rtl/step_debouncer.sv
// step_debouncer: synchronises and debounces the single-step switch, emits
// one-cycle step pulses (one per press plus optional auto-repeat while held)
// and keeps a wrapping count of issued steps for the display.
module step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_raw,
  input  logic       repeat_en,
  output logic       sw_level,
  output logic       step,
  output logic [7:0] step_count
);

  // A period of 1 would make back-to-back pulses; the same holds for a delay
  // of 1 right after the press step, so both are held to at least 2.
  localparam int PER_EFF = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
  localparam int DLY_EFF = (REPEAT_DELAY  < 2) ? 2 : REPEAT_DELAY;
  localparam int REP_MAX = DLY_EFF + PER_EFF;

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1) + 1;
  localparam int REP_W = $clog2(REP_MAX + 1) + 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [REP_W-1:0] REP_DLY  = REP_W'(DLY_EFF);
  localparam logic [REP_W-1:0] REP_WRAP = REP_W'(REP_MAX);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic             sync1, sw_sync;
  logic [DB_W-1:0]  db_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_nxt;

  assign rep_nxt = rep_cnt + REP_W'(1);

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sync1   <= sw_raw;
      sw_sync <= sync1;
    end
  end

  // Debounce / repeat FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RELEASED;
      db_cnt     <= '0;
      rep_cnt    <= '0;
      sw_level   <= 1'b0;
      step       <= 1'b0;
      step_count <= '0;
    end else begin
      step <= 1'b0;
      case (state)
        RELEASED: begin
          if (sw_sync) begin
            state  <= PRESS_WAIT;
            db_cnt <= DB_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sw_sync) begin
            state <= RELEASED;
          end else if (db_cnt == DB_LAST) begin
            state      <= PRESSED;
            sw_level   <= 1'b1;
            rep_cnt    <= '0;
            step       <= 1'b1;
            step_count <= step_count + 8'd1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!sw_sync) begin
            state  <= RELEASE_WAIT;
            db_cnt <= DB_W'(1);
          end else if (!repeat_en) begin
            rep_cnt <= '0;
          end else if (rep_nxt == REP_WRAP) begin
            // Fold back to the delay point so the counter never grows past
            // delay+period while the button stays held.
            rep_cnt    <= REP_DLY;
            step       <= 1'b1;
            step_count <= step_count + 8'd1;
          end else begin
            rep_cnt <= rep_nxt;
            if (rep_nxt == REP_DLY) begin
              step       <= 1'b1;
              step_count <= step_count + 8'd1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (sw_sync) begin
            state   <= PRESSED;
            rep_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state    <= RELEASED;
            sw_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule
